enemy_controller: RTL and testbench

ENEMY_CONTROLLER -- requirements
Module: enemy_controller

---
 rtl/race_pkg.sv | 33 +++
 rtl/box_overlap.sv | 34 +++
 rtl/enemy_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_enemy_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// race_pkg -- shared definitions for the racing game blocks.
//
// Holds the car geometry, the screen limit below which an enemy counts as
// parked, the game FSM encoding and the spawn lane table. The enemy,
// renderer and enemy_controller blocks all import this package so they
// agree on sizes and columns.
package race_pkg;

    // Car sprite size in pixels (player and enemies share it).
    localparam int CAR_W         = 80;
    localparam int CAR_H         = 121;
    // An enemy whose top edge is at or below this y is off-screen / parked.
    localparam int SCREEN_BOTTOM = 600;

    // Game FSM encoding; the numeric values are visible on the state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CRASH = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Spawn columns (x of the car's left edge) indexed by a 2-bit lane.
    function automatic logic [9:0] lane_x(input logic [1:0] idx);
        case (idx)
            2'd0:    lane_x = 10'd120;
            2'd1:    lane_x = 10'd240;
            2'd2:    lane_x = 10'd360;
            default: lane_x = 10'd480;
        endcase
    endfunction

endpackage

// File: rtl/box_overlap.sv
// box_overlap -- combinational test for two equally sized axis-aligned boxes.
//
// Ports:
//   ax, ay : in  10  top-left of box A
//   bx, by : in  10  top-left of box B
//   hit    : out 1   boxes overlap (touching edges do not count)
//
// Right/bottom edges are formed in 11 bits so a box near the 10-bit limit
// cannot wrap around and fake an overlap.
module box_overlap #(
    parameter int W = 80,
    parameter int H = 121
) (
    input  logic [9:0] ax,
    input  logic [9:0] ay,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    output logic       hit
);

    logic [10:0] ax_end;
    logic [10:0] ay_end;
    logic [10:0] bx_end;
    logic [10:0] by_end;

    assign ax_end = {1'b0, ax} + 11'(W);
    assign ay_end = {1'b0, ay} + 11'(H);
    assign bx_end = {1'b0, bx} + 11'(W);
    assign by_end = {1'b0, by} + 11'(H);

    assign hit = ({1'b0, ax} < bx_end) && ({1'b0, bx} < ax_end) &&
                 ({1'b0, ay} < by_end) && ({1'b0, by} < ay_end);

endmodule

// File: rtl/enemy_controller.sv
// enemy_controller -- game flow for two enemy cars.
//
// Spawns enemies into pseudo-random lanes, counts cars that drive off the
// bottom of the screen, detects player/enemy collisions, holds the crash
// freeze and tracks lives until game over.
//
// Ports:
//   logic_clk                  in  1   game logic clock
//   reset                      in  1   synchronous, active-high
//   start                      in  1   level-sampled start (IDLE / OVER only)
//   player_x, player_y         in  10  player car top-left
//   enemy{0,1}_pos_x/_pos_y    in  10  enemy car top-left
//   enemy{0,1}_offset_x        out 10  spawn column for each enemy
//   enemy{0,1}_enable          out 1   one-cycle spawn pulse
//   enemy_reset                out 1   one-cycle pulse parking both enemies
//   collision                  out 1   freeze enemies (CRASH / OVER)
//   score                      out 16  cars passed, saturating
//   lives                      out 2   remaining lives
//   state                      out 2   current FSM state
// All outputs come straight from registers.
module enemy_controller #(
    parameter int CAR_W         = race_pkg::CAR_W,
    parameter int CAR_H         = race_pkg::CAR_H,
    parameter int SCREEN_BOTTOM = race_pkg::SCREEN_BOTTOM,
    parameter int SPAWN_GAP     = 200,
    parameter int CRASH_CYCLES  = 120,
    parameter int LIVES_INIT    = 3
) (
    input  logic        logic_clk,
    input  logic        reset,
    input  logic        start,
    input  logic [9:0]  player_x,
    input  logic [9:0]  player_y,
    input  logic [9:0]  enemy0_pos_x,
    input  logic [9:0]  enemy0_pos_y,
    input  logic [9:0]  enemy1_pos_x,
    input  logic [9:0]  enemy1_pos_y,
    output logic [9:0]  enemy0_offset_x,
    output logic [9:0]  enemy1_offset_x,
    output logic        enemy0_enable,
    output logic        enemy1_enable,
    output logic        enemy_reset,
    output logic        collision,
    output logic [15:0] score,
    output logic [1:0]  lives,
    output logic [1:0]  state
);

    import race_pkg::*;

    localparam int         TIMER_W = $clog2(SPAWN_GAP + 1);
    localparam int         CNT_W   = $clog2(CRASH_CYCLES + 1);
    localparam logic [9:0] BOTTOM  = 10'(SCREEN_BOTTOM);

    state_t               cur_state;
    state_t               next_state;
    logic [7:0]           lfsr_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [TIMER_W-1:0]   timer_d;
    logic [CNT_W-1:0]     crash_cnt_q;
    logic [CNT_W-1:0]     crash_cnt_d;
    logic [9:0]           prev_y0_q;
    logic [9:0]           prev_y1_q;

    logic [9:0]           offset0_d;
    logic [9:0]           offset1_d;
    logic                 enable0_d;
    logic                 enable1_d;
    logic                 enemy_reset_d;
    logic                 collision_d;
    logic [15:0]          score_d;
    logic [1:0]           lives_d;

    // ------------------------------------------------------------------
    // Collision, pass and spawn-eligibility detection
    // ------------------------------------------------------------------
    logic below0, below1;
    logic box_hit0, box_hit1;
    logic any_hit;
    logic pass0, pass1;
    logic [16:0] score_sum;
    logic [1:0]  lane_idx;
    logic [1:0]  lane_alt;
    logic [9:0]  pick0, pick1;

    box_overlap #(.W(CAR_W), .H(CAR_H)) u_overlap0 (
        .ax  (player_x),
        .ay  (player_y),
        .bx  (enemy0_pos_x),
        .by  (enemy0_pos_y),
        .hit (box_hit0)
    );

    box_overlap #(.W(CAR_W), .H(CAR_H)) u_overlap1 (
        .ax  (player_x),
        .ay  (player_y),
        .bx  (enemy1_pos_x),
        .by  (enemy1_pos_y),
        .hit (box_hit1)
    );

    // A parked enemy (at or below the screen bottom) can never hit the player.
    assign below0  = enemy0_pos_y < BOTTOM;
    assign below1  = enemy1_pos_y < BOTTOM;
    assign any_hit = (below0 && box_hit0) || (below1 && box_hit1);

    // A pass is the crossing edge only; an enemy sitting parked counts once.
    assign pass0 = (prev_y0_q < BOTTOM) && !below0;
    assign pass1 = (prev_y1_q < BOTTOM) && !below1;
    assign score_sum = 17'(score) + 17'(pass0) + 17'(pass1);

    // Never stack both enemies in one column: step to the next lane instead.
    assign lane_idx = lfsr_q[1:0];
    assign lane_alt = lane_idx + 2'd1;
    assign pick0 = (lane_x(lane_idx) == enemy1_offset_x) ? lane_x(lane_alt)
                                                          : lane_x(lane_idx);
    assign pick1 = (lane_x(lane_idx) == enemy0_offset_x) ? lane_x(lane_alt)
                                                          : lane_x(lane_idx);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge logic_clk) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= next_state;
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (any_hit) next_state = CRASH;
            CRASH:   if (crash_cnt_q == '0) next_state = (lives == 2'd0) ? OVER : RUN;
            OVER:    if (start) next_state = RUN;
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath next values (registered below)
    // ------------------------------------------------------------------
    always_comb begin
        offset0_d     = enemy0_offset_x;
        offset1_d     = enemy1_offset_x;
        enable0_d     = 1'b0;
        enable1_d     = 1'b0;
        enemy_reset_d = 1'b0;
        collision_d   = (next_state == CRASH) || (next_state == OVER);
        score_d       = score;
        lives_d       = lives;
        timer_d       = (timer_q == '0) ? '0 : timer_q - 1'b1;
        crash_cnt_d   = crash_cnt_q;

        case (cur_state)
            IDLE, OVER: begin
                if (start) begin
                    score_d       = 16'd0;
                    lives_d       = 2'(LIVES_INIT);
                    enemy_reset_d = 1'b1;
                    timer_d       = '0;
                end
            end
            RUN: begin
                if (any_hit) begin
                    // The crash wins over any pass in the same cycle.
                    lives_d     = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                    crash_cnt_d = CNT_W'(CRASH_CYCLES - 1);
                end else begin
                    score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    // enemy0 has priority; enemy1 waits for the next expiry.
                    if (timer_q == '0 && !below0) begin
                        enable0_d = 1'b1;
                        offset0_d = pick0;
                        timer_d   = TIMER_W'(SPAWN_GAP);
                    end else if (timer_q == '0 && !below1) begin
                        enable1_d = 1'b1;
                        offset1_d = pick1;
                        timer_d   = TIMER_W'(SPAWN_GAP);
                    end
                end
            end
            CRASH: begin
                if (crash_cnt_q == '0) begin
                    if (lives != 2'd0) begin
                        enemy_reset_d = 1'b1;
                        timer_d       = TIMER_W'(SPAWN_GAP);
                    end
                end else begin
                    crash_cnt_d = crash_cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge logic_clk) begin
        if (reset) begin
            enemy0_offset_x <= 10'd0;
            enemy1_offset_x <= 10'd0;
            enemy0_enable   <= 1'b0;
            enemy1_enable   <= 1'b0;
            enemy_reset     <= 1'b1;
            collision       <= 1'b0;
            score           <= 16'd0;
            lives           <= 2'd0;
            timer_q         <= '0;
            crash_cnt_q     <= '0;
            lfsr_q          <= 8'h5A;
            // Treat enemies as parked so release never fakes a pass.
            prev_y0_q       <= BOTTOM;
            prev_y1_q       <= BOTTOM;
        end else begin
            enemy0_offset_x <= offset0_d;
            enemy1_offset_x <= offset1_d;
            enemy0_enable   <= enable0_d;
            enemy1_enable   <= enable1_d;
            enemy_reset     <= enemy_reset_d;
            collision       <= collision_d;
            score           <= score_d;
            lives           <= lives_d;
            timer_q         <= timer_d;
            crash_cnt_q     <= crash_cnt_d;
            // Fibonacci LFSR, taps 8,6,5,4; runs in every state.
            lfsr_q          <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            prev_y0_q       <= enemy0_pos_y;
            prev_y1_q       <= enemy1_pos_y;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_enemy_controller.sv
// tb_enemy_controller -- directed self-checking bench for enemy_controller.
module tb_enemy_controller;

    logic        logic_clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  player_x, player_y;
    logic [9:0]  enemy0_pos_x, enemy0_pos_y;
    logic [9:0]  enemy1_pos_x, enemy1_pos_y;
    logic [9:0]  enemy0_offset_x, enemy1_offset_x;
    logic        enemy0_enable, enemy1_enable;
    logic        enemy_reset, collision;
    logic [15:0] score;
    logic [1:0]  lives;
    logic [1:0]  state;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference LFSR (taps 8,6,5,4 as a mask) used only to predict lanes.
    logic [7:0] m_lfsr;

    always #5 logic_clk = ~logic_clk;

    always @(posedge logic_clk) begin
        if (reset) m_lfsr <= 8'h5A;
        else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end

    enemy_controller dut (
        .logic_clk       (logic_clk),
        .reset           (reset),
        .start           (start),
        .player_x        (player_x),
        .player_y        (player_y),
        .enemy0_pos_x    (enemy0_pos_x),
        .enemy0_pos_y    (enemy0_pos_y),
        .enemy1_pos_x    (enemy1_pos_x),
        .enemy1_pos_y    (enemy1_pos_y),
        .enemy0_offset_x (enemy0_offset_x),
        .enemy1_offset_x (enemy1_offset_x),
        .enemy0_enable   (enemy0_enable),
        .enemy1_enable   (enemy1_enable),
        .enemy_reset     (enemy_reset),
        .collision       (collision),
        .score           (score),
        .lives           (lives),
        .state           (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit before sampling/driving.
    task automatic step(input int n = 1);
        repeat (n) @(posedge logic_clk);
        #1;
    endtask

    function automatic logic [9:0] tb_lane(input logic [1:0] idx);
        logic [9:0] table_x [4];
        table_x = '{10'd120, 10'd240, 10'd360, 10'd480};
        return table_x[idx];
    endfunction

    // Crash with enemy0 on top of the player, then park it and wait out the freeze.
    task automatic crash_and_hold(input logic [1:0] exp_lives, input string tag);
        enemy0_pos_x = 10'd240;
        enemy0_pos_y = 10'd300;
        step();
        check({tag, "_state"}, state, 2);
        check({tag, "_coll"}, collision, 1);
        check({tag, "_lives"}, lives, exp_lives);
        enemy0_pos_x = 10'd0;
        enemy0_pos_y = 10'd620;
        step(119);
        check({tag, "_hold"}, state, 2);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] exp0, exp1;
        logic       seen;

        reset        = 1'b1;
        start        = 1'b0;
        player_x     = 10'd240;
        player_y     = 10'd350;
        enemy0_pos_x = 10'd0;
        enemy0_pos_y = 10'd620;
        enemy1_pos_x = 10'd0;
        enemy1_pos_y = 10'd620;

        // Reset values
        step(2);
        check("rst_state", state, 0);
        check("rst_coll", collision, 0);
        check("rst_lives", lives, 0);
        check("rst_score", score, 0);
        check("rst_ereset", enemy_reset, 1);
        check("rst_en0", enemy0_enable, 0);
        check("rst_off0", enemy0_offset_x, 0);
        check("rst_off1", enemy1_offset_x, 0);

        reset = 1'b0;
        step();
        check("rel_ereset", enemy_reset, 0);
        check("rel_state", state, 0);

        // Start: enemy_reset pulse, RUN, enemy0 spawns first RUN cycle
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_state", state, 1);
        check("start_ereset", enemy_reset, 1);
        check("start_lives", lives, 3);
        check("start_score", score, 0);
        exp0 = tb_lane(m_lfsr[1:0]);   // other offset is 0: no conflict possible
        step();
        check("spawn0_en", enemy0_enable, 1);
        check("spawn0_en1", enemy1_enable, 0);
        check("spawn0_off", enemy0_offset_x, exp0);
        check("spawn0_ereset", enemy_reset, 0);
        // enemy0 now on screen, well clear of the player
        enemy0_pos_x = 10'd0;
        enemy0_pos_y = 10'd0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            seen = seen | enemy1_enable | enemy0_enable;
        end
        check("gap_no_spawn", seen, 0);
        exp1 = tb_lane(m_lfsr[1:0]);
        if (exp1 == exp0) exp1 = tb_lane(m_lfsr[1:0] + 2'd1);
        step();
        check("spawn1_en", enemy1_enable, 1);
        check("spawn1_off", enemy1_offset_x, exp1);

        // Pass counting: 599 -> 600 once, held 600 does not recount
        enemy1_pos_y = 10'd599;
        enemy0_pos_y = 10'd599;
        step();
        enemy0_pos_y = 10'd600;
        step();
        check("pass_one", score, 1);
        step(3);
        check("pass_held", score, 1);
        // Two crossings in one cycle add 2
        enemy0_pos_y = 10'd599;
        step();
        enemy0_pos_y = 10'd600;
        enemy1_pos_y = 10'd600;
        step();
        check("pass_two", score, 3);

        // Edge touch at x=320 is not an overlap
        player_x     = 10'd320;
        enemy0_pos_x = 10'd240;
        enemy0_pos_y = 10'd350;
        enemy1_pos_y = 10'd599;
        step();
        check("touch_state", state, 1);
        check("touch_coll", collision, 0);
        // x=319 overlaps; a simultaneous enemy1 pass must not score
        enemy0_pos_x = 10'd319;
        enemy1_pos_y = 10'd600;
        step();
        check("hit_state", state, 2);
        check("hit_coll", collision, 1);
        check("hit_lives", lives, 2);
        check("hit_noscore", score, 3);
        enemy0_pos_x = 10'd0;
        enemy0_pos_y = 10'd620;
        start = 1'b1;              // ignored in CRASH
        step(60);
        start = 1'b0;
        check("crash_start_ign", state, 2);
        step(59);
        check("crash_hold", state, 2);
        check("crash_hold_coll", collision, 1);
        step();
        check("recover_state", state, 1);
        check("recover_coll", collision, 0);
        check("recover_ereset", enemy_reset, 1);
        step();
        check("recover_ereset_end", enemy_reset, 0);

        // Second and third crashes -> OVER
        player_x = 10'd240;
        crash_and_hold(2'd1, "c2");
        check("c2_run", state, 1);
        crash_and_hold(2'd0, "c3");
        check("over_state", state, 3);
        check("over_coll", collision, 1);
        check("over_ereset", enemy_reset, 0);
        step(5);
        check("over_stay", state, 3);
        check("over_score", score, 3);
        check("over_lives", lives, 0);

        // Restart from OVER
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        check("restart_lives", lives, 3);
        check("restart_coll", collision, 0);
        check("restart_ereset", enemy_reset, 1);

        // Reset in the middle of a crash
        enemy0_pos_x = 10'd240;
        enemy0_pos_y = 10'd300;
        step();
        check("c4_state", state, 2);
        enemy0_pos_y = 10'd620;
        step(10);
        reset = 1'b1;
        step();
        check("midrst_state", state, 0);
        check("midrst_coll", collision, 0);
        check("midrst_lives", lives, 0);
        check("midrst_ereset", enemy_reset, 1);
        reset = 1'b0;
        step();
        check("midrst_rel_ereset", enemy_reset, 0);
        check("midrst_rel_state", state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
